// File: rtl/id_pkg.sv
// Shared encodings for the instruction-decode stage: MIPS opcode/funct fields,
// ALU operation/result-select codes and the decoded control packet.
package id_pkg;

  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;

  localparam logic [5:0] EXE_AND = 6'b100100;
  localparam logic [5:0] EXE_OR  = 6'b100101;
  localparam logic [5:0] EXE_XOR = 6'b100110;
  localparam logic [5:0] EXE_NOR = 6'b100111;
  localparam logic [5:0] EXE_SLL = 6'b000000;
  localparam logic [5:0] EXE_SRL = 6'b000010;
  localparam logic [5:0] EXE_SRA = 6'b000011;

  typedef enum logic [7:0] {
    EXE_NOP_OP = 8'h00,
    EXE_SRL_OP = 8'h02,
    EXE_SRA_OP = 8'h03,
    EXE_AND_OP = 8'h24,
    EXE_OR_OP  = 8'h25,
    EXE_XOR_OP = 8'h26,
    EXE_NOR_OP = 8'h27,
    EXE_SLL_OP = 8'h7C
  } aluop_e;

  typedef enum logic [2:0] {
    EXE_RES_NOP   = 3'b000,
    EXE_RES_LOGIC = 3'b001,
    EXE_RES_SHIFT = 3'b010
  } alusel_e;

  typedef struct packed {
    aluop_e     aluop;
    alusel_e    alusel;
    logic [4:0] wd;
    logic       wreg;
    logic       illegal;
  } id_ctrl_t;

  localparam id_ctrl_t ID_CTRL_RST = '{
    aluop:   EXE_NOP_OP,
    alusel:  EXE_RES_NOP,
    wd:      5'd0,
    wreg:    1'b0,
    illegal: 1'b0
  };

endpackage

// File: rtl/id_decode.sv
// Purely combinational instruction decoder: control packet, register read
// enables/addresses and the immediate that replaces an unread operand.
module id_decode
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output id_ctrl_t        ctrl_o,
  output logic            re1_o,
  output logic            re2_o,
  output logic [4:0]      addr1_o,
  output logic [4:0]      addr2_o,
  output logic [XLEN-1:0] imm_o
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [15:0] imm16;

  assign op      = inst_i[31:26];
  assign rs      = inst_i[25:21];
  assign rt      = inst_i[20:16];
  assign rd      = inst_i[15:11];
  assign sh      = inst_i[10:6];
  assign fn      = inst_i[5:0];
  assign imm16   = inst_i[15:0];
  assign addr1_o = rs;
  assign addr2_o = rt;

  // The all-zero word would otherwise decode as SLL $0,$0,0; it is a true NOP.
  always_comb begin
    ctrl_o = ID_CTRL_RST;
    re1_o  = 1'b0;
    re2_o  = 1'b0;
    imm_o  = '0;
    if (inst_i != 32'h0) begin
      case (op)
        EXE_ORI, EXE_ANDI, EXE_XORI, EXE_LUI: begin
          re1_o         = 1'b1;
          ctrl_o.wd     = rt;
          ctrl_o.wreg   = 1'b1;
          ctrl_o.alusel = EXE_RES_LOGIC;
          imm_o         = XLEN'(imm16);
          case (op)
            EXE_ANDI: ctrl_o.aluop = EXE_AND_OP;
            EXE_XORI: ctrl_o.aluop = EXE_XOR_OP;
            default:  ctrl_o.aluop = EXE_OR_OP;
          endcase
          if (op == EXE_LUI) imm_o = XLEN'({imm16, 16'h0});
        end
        EXE_SPECIAL: begin
          case (fn)
            EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
              re1_o         = 1'b1;
              re2_o         = 1'b1;
              ctrl_o.wd     = rd;
              ctrl_o.wreg   = 1'b1;
              ctrl_o.alusel = EXE_RES_LOGIC;
              case (fn)
                EXE_AND: ctrl_o.aluop = EXE_AND_OP;
                EXE_OR:  ctrl_o.aluop = EXE_OR_OP;
                EXE_XOR: ctrl_o.aluop = EXE_XOR_OP;
                default: ctrl_o.aluop = EXE_NOR_OP;
              endcase
            end
            EXE_SLL, EXE_SRL, EXE_SRA: begin
              re2_o         = 1'b1;
              imm_o         = XLEN'(sh);
              ctrl_o.wd     = rd;
              ctrl_o.wreg   = 1'b1;
              ctrl_o.alusel = EXE_RES_SHIFT;
              case (fn)
                EXE_SLL: ctrl_o.aluop = EXE_SLL_OP;
                EXE_SRL: ctrl_o.aluop = EXE_SRL_OP;
                default: ctrl_o.aluop = EXE_SRA_OP;
              endcase
            end
            default: ctrl_o.illegal = 1'b1;
          endcase
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: operand forwarding from EX/MEM, load-use stall and
// a valid/ready output register toward EX with flush.
module id_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   pc_i,
  input  logic [31:0]     inst_i,
  output logic            reg1_read_o,
  output logic            reg2_read_o,
  output logic [RAW-1:0]  reg1_addr_o,
  output logic [RAW-1:0]  reg2_addr_o,
  input  logic [XLEN-1:0] reg1_data_i,
  input  logic [XLEN-1:0] reg2_data_i,
  input  logic            ex_wreg_i,
  input  logic [RAW-1:0]  ex_wd_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            ex_is_load_i,
  input  logic            mem_wreg_i,
  input  logic [RAW-1:0]  mem_wd_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   pc_o,
  output logic [7:0]      aluop_o,
  output logic [2:0]      alusel_o,
  output logic [XLEN-1:0] reg1_o,
  output logic [XLEN-1:0] reg2_o,
  output logic [RAW-1:0]  wd_o,
  output logic            wreg_o,
  output logic            illegal_o
);

  id_ctrl_t        dec_ctrl;
  logic            dec_re1, dec_re2;
  logic [4:0]      dec_addr1, dec_addr2;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] op1, op2;
  logic            stall, accept;

  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   pc_q, pc_d;
  id_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0] reg1_q, reg1_d, reg2_q, reg2_d;

  id_decode #(.XLEN(XLEN)) u_decode (
    .inst_i  (inst_i),
    .ctrl_o  (dec_ctrl),
    .re1_o   (dec_re1),
    .re2_o   (dec_re2),
    .addr1_o (dec_addr1),
    .addr2_o (dec_addr2),
    .imm_o   (dec_imm)
  );

  assign reg1_read_o = rst & dec_re1;
  assign reg2_read_o = rst & dec_re2;
  assign reg1_addr_o = RAW'(dec_addr1);
  assign reg2_addr_o = RAW'(dec_addr2);

  // The younger producer (EX) wins over MEM; $0 is never forwarded.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic re, input logic [RAW-1:0] addr,
    input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rf_data,
    input logic ex_w, input logic [RAW-1:0] ex_a, input logic [XLEN-1:0] ex_d,
    input logic mem_w, input logic [RAW-1:0] mem_a, input logic [XLEN-1:0] mem_d);
    logic [XLEN-1:0] v;
    if (!re)                         v = imm;
    else if (addr == '0)             v = '0;
    else if (ex_w && ex_a == addr)   v = ex_d;
    else if (mem_w && mem_a == addr) v = mem_d;
    else                             v = rf_data;
    return v;
  endfunction

  assign op1 = resolve_operand(dec_re1, reg1_addr_o, dec_imm, reg1_data_i, ex_wreg_i, ex_wd_i,
                               ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign op2 = resolve_operand(dec_re2, reg2_addr_o, dec_imm, reg2_data_i, ex_wreg_i, ex_wd_i,
                               ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign stall = ex_is_load_i & ex_wreg_i & (ex_wd_i != '0) &
                 ((reg1_read_o & (ex_wd_i == reg1_addr_o)) |
                  (reg2_read_o & (ex_wd_i == reg2_addr_o)));

  assign in_ready = rst & ~stall & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Flush beats accept; payload bits only move on accept so a held packet stays frozen.
  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      pc_d        = pc_i;
      ctrl_d      = dec_ctrl;
      reg1_d      = op1;
      reg2_d      = op2;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      ctrl_q      <= ID_CTRL_RST;
      reg1_q      <= '0;
      reg2_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_o      = pc_q;
  assign aluop_o   = ctrl_q.aluop;
  assign alusel_o  = ctrl_q.alusel;
  assign reg1_o    = reg1_q;
  assign reg2_o    = reg2_q;
  assign wd_o      = RAW'(ctrl_q.wd);
  assign wreg_o    = ctrl_q.wreg;
  assign illegal_o = ctrl_q.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_id_pipe;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int RAW  = 5;

  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [AW-1:0]   pc_i;
  logic [31:0]     inst_i;
  logic            reg1_read_o, reg2_read_o;
  logic [RAW-1:0]  reg1_addr_o, reg2_addr_o;
  logic [XLEN-1:0] reg1_data_i, reg2_data_i;
  logic            ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [RAW-1:0]  ex_wd_i, mem_wd_i;
  logic [XLEN-1:0] ex_wdata_i, mem_wdata_i;
  logic            flush_i, out_valid, out_ready;
  logic [AW-1:0]   pc_o;
  logic [7:0]      aluop_o;
  logic [2:0]      alusel_o;
  logic [XLEN-1:0] reg1_o, reg2_o;
  logic [RAW-1:0]  wd_o;
  logic            wreg_o, illegal_o;

  int total = 0;
  int bad   = 0;

  id_pipe #(.XLEN(XLEN), .AW(AW), .RAW(RAW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // Model state: what EX should currently be seeing.
  logic        m_valid = 1'b0, m_wreg = 1'b0, m_ill = 1'b0;
  logic [31:0] m_pc = '0, m_r1 = '0, m_r2 = '0;
  logic [7:0]  m_aluop = OP_NOP;
  logic [2:0]  m_alusel = SEL_NOP;
  logic [4:0]  m_wd = '0;

  // Model combinational view of the current cycle.
  logic        e_re1, e_re2, e_wreg, e_ill, e_stall, e_ready;
  logic [7:0]  e_aluop;
  logic [2:0]  e_alusel;
  logic [4:0]  e_wd, e_rs, e_rt;
  logic [31:0] e_imm, e_r1, e_r2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] operand(input logic used, input logic [4:0] a,
                                          input logic [31:0] imm, input logic [31:0] rf);
    if (!used) return imm;
    if (a == 5'd0) return 32'h0;
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf;
  endfunction

  task automatic model_comb();
    logic [5:0]  op, fn;
    logic [4:0]  rd, sh;
    logic [15:0] im;
    op = inst_i[31:26]; e_rs = inst_i[25:21]; e_rt = inst_i[20:16];
    rd = inst_i[15:11]; sh = inst_i[10:6]; fn = inst_i[5:0]; im = inst_i[15:0];
    e_re1 = 0; e_re2 = 0; e_wreg = 0; e_ill = 0; e_wd = 0; e_imm = 0;
    e_aluop = OP_NOP; e_alusel = SEL_NOP;
    if (inst_i == 32'h0) begin
    end else if (op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F) begin
      e_re1 = 1; e_wreg = 1; e_wd = e_rt; e_alusel = SEL_LOGIC;
      e_imm = (op == 6'h0F) ? {im, 16'h0} : {16'h0, im};
      e_aluop = (op == 6'h0C) ? OP_AND : (op == 6'h0E) ? OP_XOR : OP_OR;
    end else if (op == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
      e_re1 = 1; e_re2 = 1; e_wreg = 1; e_wd = rd; e_alusel = SEL_LOGIC;
      case (fn)
        6'h24:   e_aluop = OP_AND;
        6'h25:   e_aluop = OP_OR;
        6'h26:   e_aluop = OP_XOR;
        default: e_aluop = OP_NOR;
      endcase
    end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
      e_re2 = 1; e_wreg = 1; e_wd = rd; e_alusel = SEL_SHIFT; e_imm = {27'h0, sh};
      e_aluop = (fn == 6'h00) ? OP_SLL : (fn == 6'h02) ? OP_SRL : OP_SRA;
    end else begin
      e_ill = 1;
    end
    e_r1 = operand(e_re1, e_rs, e_imm, reg1_data_i);
    e_r2 = operand(e_re2, e_rt, e_imm, reg2_data_i);
    e_stall = rst && ex_is_load_i && ex_wreg_i && ex_wd_i != 0 &&
              ((e_re1 && ex_wd_i == e_rs) || (e_re2 && ex_wd_i == e_rt));
    e_ready = rst && !e_stall && (!m_valid || out_ready);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_wd = 0; m_wreg = 0; m_ill = 0;
      m_aluop = OP_NOP; m_alusel = SEL_NOP;
    end else begin
      model_comb();
      if (flush_i) m_valid = 0;
      else if (in_valid && e_ready) begin
        m_valid = 1; m_pc = pc_i; m_r1 = e_r1; m_r2 = e_r2; m_wd = e_wd;
        m_wreg = e_wreg; m_ill = e_ill; m_aluop = e_aluop; m_alusel = e_alusel;
      end else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    model_comb();
    check("in_ready", in_ready, e_ready);
    check("reg1_read", reg1_read_o, e_re1 & rst);
    check("reg2_read", reg2_read_o, e_re2 & rst);
    if (rst) begin
      check("reg1_addr", reg1_addr_o, e_rs);
      check("reg2_addr", reg2_addr_o, e_rt);
    end
    check("out_valid", out_valid, m_valid);
    check("pc_o", pc_o, m_pc);
    check("aluop_o", aluop_o, m_aluop);
    check("alusel_o", alusel_o, m_alusel);
    check("reg1_o", reg1_o, m_r1);
    check("reg2_o", reg2_o, m_r2);
    check("wd_o", wd_o, m_wd);
    check("wreg_o", wreg_o, m_wreg);
    check("illegal_o", illegal_o, m_ill);
  end

  task automatic drive_idle();
    in_valid = 0; pc_i = 0; inst_i = 0; reg1_data_i = 0; reg2_data_i = 0;
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0; flush_i = 0; out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] im;
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 7));
    sh = 5'($urandom); im = 16'($urandom);
    case ($urandom_range(0, 13))
      0:  return {6'h0D, rs, rt, im};
      1:  return {6'h0C, rs, rt, im};
      2:  return {6'h0E, rs, rt, im};
      3:  return {6'h0F, 5'd0, rt, im};
      4:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      5:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      6:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      7:  return {6'h00, rs, rt, rd, 5'd0, 6'h27};
      8:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
      9:  return {6'h00, 5'd0, rt, rd, sh, 6'h02};
      10: return {6'h00, 5'd0, rt, rd, sh, 6'h03};
      11: return 32'h0;
      12: return {6'h3F, rs, rt, im};
      default: return {6'h00, rs, rt, rd, 5'd0, 6'h3A};
    endcase
  endfunction

  task automatic issue();
    in_valid = 1;
    tick();
    in_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    drive_idle();
    inst_i = {6'h0D, 5'd1, 5'd2, 16'hFF00};
    #1 rst = 0;
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst aluop", aluop_o, OP_NOP);
    check("rst in_ready", in_ready, 0);
    check("rst reg1_read", reg1_read_o, 0);
    tick();
    rst = 1;

    // ORI $2,$1,0xFF00 with $1 = 0xF0
    pc_i = 32'h100; reg1_data_i = 32'hF0; reg2_data_i = 32'hDEAD;
    in_valid = 1;
    @(negedge clk);
    check("ori in_ready", in_ready, 1);
    check("ori reg1_read", reg1_read_o, 1);
    check("ori reg2_read", reg2_read_o, 0);
    check("ori reg1_addr", reg1_addr_o, 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    check("ori valid", out_valid, 1);
    check("ori reg1", reg1_o, 32'hF0);
    check("ori reg2", reg2_o, 32'hFF00);
    check("ori wd", wd_o, 2);
    check("ori wreg", wreg_o, 1);
    check("ori aluop", aluop_o, OP_OR);
    check("ori alusel", alusel_o, SEL_LOGIC);

    // OR $3,$1,$2: EX supplies $1, MEM supplies $2
    tick();
    pc_i = 32'h104; inst_i = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25};
    reg1_data_i = 32'hAAAA; reg2_data_i = 32'hBBBB;
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'h11;
    mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 32'h33;
    issue();
    check("fwd ex reg1", reg1_o, 32'h11);
    check("fwd mem reg2", reg2_o, 32'h33);
    check("or wd", wd_o, 3);

    // EX and MEM both target $1: EX wins
    tick();
    mem_wd_i = 1; mem_wdata_i = 32'h22; reg2_data_i = 32'h44;
    issue();
    check("ex over mem", reg1_o, 32'h11);
    check("rf reg2", reg2_o, 32'h44);

    // EX writing $0 never forwards
    tick();
    inst_i = {6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h25};
    ex_wd_i = 0; ex_wdata_i = 32'h5; mem_wreg_i = 0; reg1_data_i = 32'h99;
    issue();
    check("zero reg1", reg1_o, 0);

    // Load-use on $4: AND $5,$4,$4
    tick();
    pc_i = 32'h108; inst_i = {6'h00, 5'd4, 5'd4, 5'd5, 5'd0, 6'h24};
    reg1_data_i = 32'h4444; reg2_data_i = 32'h5555;
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 4; in_valid = 1;
    @(negedge clk);
    check("loaduse in_ready", in_ready, 0);
    tick();
    ex_is_load_i = 0; ex_wreg_i = 0;
    @(negedge clk);
    check("loaduse bubble", out_valid, 0);
    check("loaduse retry ready", in_ready, 1);
    tick();
    out_ready = 0; pc_i = 32'h10C; inst_i = {6'h0E, 5'd1, 5'd6, 16'h1234};
    @(negedge clk);
    check("and valid", out_valid, 1);
    check("and wd", wd_o, 5);

    // Backpressure while EX/MEM buses churn
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_wreg_i = 1; ex_wd_i = 4; ex_wdata_i = $urandom;
      mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = $urandom;
      @(negedge clk);
      check("hold in_ready", in_ready, 0);
      check("hold valid", out_valid, 1);
      check("hold reg1", reg1_o, 32'h4444);
      check("hold reg2", reg2_o, 32'h5555);
      check("hold wd", wd_o, 5);
    end
    tick();
    out_ready = 1; ex_wreg_i = 0; mem_wreg_i = 0;
    tick();
    out_ready = 0;
    @(negedge clk);
    check("xori wd", wd_o, 6);
    check("xori aluop", aluop_o, OP_XOR);

    // Flush with a held packet and a valid incoming instruction
    pc_i = 32'h110; inst_i = {6'h0D, 5'd1, 5'd7, 16'h0001}; flush_i = 1;
    issue();
    flush_i = 0;
    check("flush valid", out_valid, 0);

    // Unknown opcode still delivered, flagged illegal
    pc_i = 32'h114; inst_i = 32'hFC00_0000; out_ready = 1;
    in_valid = 1;
    tick();
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    check("illegal valid", out_valid, 1);
    check("illegal flag", illegal_o, 1);
    check("illegal wreg", wreg_o, 0);
    check("illegal pc", pc_o, 32'h114);

    // Asynchronous reset between clock edges
    #2 rst = 0;
    #1;
    check("async valid", out_valid, 0);
    check("async illegal", illegal_o, 0);
    check("async wreg", wreg_o, 0);
    check("async pc", pc_o, 0);
    check("async aluop", aluop_o, OP_NOP);
    check("async reg1", reg1_o, 0);
    tick();
    rst = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst          = ($urandom_range(0, 149) != 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      pc_i         = $urandom;
      inst_i       = gen_inst();
      reg1_data_i  = $urandom;
      reg2_data_i  = $urandom;
      ex_wreg_i    = $urandom_range(0, 1) == 1;
      ex_wd_i      = 5'($urandom_range(0, 3));
      ex_wdata_i   = $urandom;
      ex_is_load_i = ($urandom_range(0, 3) == 0);
      mem_wreg_i   = $urandom_range(0, 1) == 1;
      mem_wd_i     = 5'($urandom_range(0, 3));
      mem_wdata_i  = $urandom;
    end
    tick();
    rst = 1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
